nibble_seq_alu: RTL and testbench

- Multi-cycle controller that acts as the initiator for the team's 4-bit combinational ALU.
- Performs NIBBLES*4-bit operations (default 16-bit) by driving the ALU one nibble per cycle, LSB first, and chaining carry/borrow through a register.
- Sits between a command source (switches/host FSM) and one external 4-bit ALU instance.
- Uses a start/busy/done handshake.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/nibble_seq_alu.sv | 121 ++++++++++++
 tb/tb_nibble_seq_alu.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types for the nibble-serial ALU controller and its 4-bit ALU partner.
package alu_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [2:0] {
    OP_NOT = 3'b000,
    OP_AND = 3'b010,
    OP_OR  = 3'b100,
    OP_XOR = 3'b110,
    OP_ADD = 3'b001,
    OP_SUB = 3'b011
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } seq_state_t;

endpackage

// File: rtl/nibble_seq_alu.sv
// Drives an external 4-bit ALU one nibble per cycle (LSB first) to build a
// NIBBLES*4-bit result, chaining carry/borrow through carry_q.
module nibble_seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [2:0]                op,
  input  logic [NIBBLE_W*NIBBLES-1:0] opa,
  input  logic [NIBBLE_W*NIBBLES-1:0] opb,
  input  logic                      cin,
  output logic [NIBBLE_W-1:0]       alu_a,
  output logic [NIBBLE_W-1:0]       alu_b,
  output logic [2:0]                alu_sel,
  output logic                      alu_cin,
  input  logic [NIBBLE_W-1:0]       alu_y,
  input  logic                      alu_cout,
  output logic                      busy,
  output logic                      done,
  output logic [NIBBLE_W*NIBBLES-1:0] result,
  output logic                      cout,
  output logic                      zero
);

  localparam int unsigned W  = NIBBLE_W * NIBBLES;
  localparam int unsigned CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  seq_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  opa_q, opb_q, result_q, result_nxt;
  logic [2:0]    op_q;
  logic          carry_q, cout_q, zero_q;
  logic          last;

  assign last = (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    busy    = 1'b1;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = RUN;
      end
      RUN:     if (last) state_d = DONE;
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ALU inputs are only driven while slicing; quiet otherwise.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = '0;
    alu_cin = 1'b0;
    if (state_q == RUN) begin
      alu_a   = opa_q[NIBBLE_W*cnt_q +: NIBBLE_W];
      alu_b   = opb_q[NIBBLE_W*cnt_q +: NIBBLE_W];
      alu_sel = op_q;
      alu_cin = carry_q;
    end
  end

  // Result with the current slice merged in, so zero sees the final nibble.
  always_comb begin
    result_nxt = result_q;
    result_nxt[NIBBLE_W*cnt_q +: NIBBLE_W] = alu_y;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      op_q     <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            opa_q    <= opa;
            opb_q    <= opb;
            op_q     <= op;
            carry_q  <= cin;
            cnt_q    <= '0;
            result_q <= '0;
          end
        end
        RUN: begin
          result_q <= result_nxt;
          carry_q  <= alu_cout;
          cnt_q    <= last ? '0 : cnt_q + CW'(1);
          if (last) begin
            cout_q <= alu_cout;
            zero_q <= (result_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign result = result_q;
  assign cout   = cout_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_nibble_seq_alu.sv
// Bench for nibble_seq_alu wired to a behavioural 4-bit ALU, checked against
// a whole-word arithmetic reference.
module tb_nibble_seq_alu;
  import alu_pkg::*;

  localparam int unsigned NIB = 4;
  localparam int unsigned W   = 16;

  logic         clk = 1'b0;
  logic         rst, start, cin;
  logic [2:0]   op;
  logic [W-1:0] opa, opb;
  logic [3:0]   alu_a, alu_b, alu_y;
  logic [2:0]   alu_sel;
  logic         alu_cin, alu_cout;
  logic         busy, done, cout, zero;
  logic [W-1:0] result;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  nibble_seq_alu #(.NIBBLES(NIB)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
    .cin(cin), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_cin(alu_cin), .alu_y(alu_y), .alu_cout(alu_cout), .busy(busy),
    .done(done), .result(result), .cout(cout), .zero(zero)
  );

  // External 4-bit ALU partner.
  always_comb begin
    alu_y    = '0;
    alu_cout = 1'b0;
    case (alu_sel)
      3'b000: alu_y = ~alu_a;
      3'b010: alu_y = alu_a & alu_b;
      3'b100: alu_y = alu_a | alu_b;
      3'b110: alu_y = alu_a ^ alu_b;
      3'b001: {alu_cout, alu_y} = 5'(alu_a) + 5'(alu_b) + 5'(alu_cin);
      3'b011: begin
        alu_y    = alu_a - alu_b - 4'(alu_cin);
        alu_cout = (5'(alu_a) < 5'(alu_b) + 5'(alu_cin));
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_op(input logic [2:0] o, input logic [W-1:0] a, b,
                                 input logic ci, output logic [W-1:0] r, output logic c);
    int unsigned ai, bi, s;
    ai = a;
    bi = b;
    r  = '0;
    c  = 1'b0;
    case (o)
      3'b000: r = ~a;
      3'b010: r = a & b;
      3'b100: r = a | b;
      3'b110: r = a ^ b;
      3'b001: begin
        s = ai + bi + ci;
        r = W'(s);
        c = (s >= 32'h1_0000);
      end
      3'b011: begin
        r = W'(ai - bi - ci);
        c = (ai < bi + ci);
      end
      default: ;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, b,
                        input logic ci, input bit poke, input string tag);
    logic [W-1:0] er;
    logic         ec;
    int           n;
    bit           seen;
    ref_op(o, a, b, ci, er, ec);
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b; cin = ci;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    opa = W'($urandom); opb = W'($urandom); cin = 1'($urandom);
    n = 1;
    seen = 0;
    while (!seen && n < 20) begin
      if (done) seen = 1;
      else begin
        if (poke && n == 2) begin
          start = 1'b1;
          op    = 3'($urandom);
          opa   = W'($urandom);
          opb   = W'($urandom);
        end else start = 1'b0;
        @(posedge clk);
        n++;
        @(negedge clk);
      end
    end
    start = 1'b0;
    check({tag, " latency"}, 32'(n), 32'd5);
    check({tag, " result"}, 32'(result), 32'(er));
    check({tag, " cout"}, 32'(cout), 32'(ec));
    check({tag, " zero"}, 32'(zero), 32'(er == '0));
    check({tag, " busy_in_done"}, 32'(busy), 32'd1);
    @(negedge clk);
    check({tag, " done_one_cycle"}, 32'({done, busy}), 32'd0);
  endtask

  initial begin
    int first_done, second_done, cyc, pulses;
    logic [W-1:0] er;
    logic         ec;

    rst = 1'b1; start = 1'b0; op = '0; opa = '0; opb = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'({busy, done, cout, zero, result}), 32'd0);
    check("reset_alu_drive", 32'({alu_a, alu_b, alu_sel, alu_cin}), 32'd0);
    rst = 1'b0;

    // Directed arithmetic, logic and reserved cases
    run_op(3'(OP_ADD), 16'h1234, 16'h0FFF, 1'b0, 0, "add");
    run_op(3'(OP_ADD), 16'hFFFF, 16'h0001, 1'b0, 0, "add_wrap");
    run_op(3'(OP_ADD), 16'h00FF, 16'h0000, 1'b1, 0, "add_cin");
    run_op(3'(OP_SUB), 16'h1000, 16'h0001, 1'b0, 0, "sub");
    run_op(3'(OP_AND), 16'hF0F0, 16'h3C3C, 1'b1, 0, "and");
    run_op(3'(OP_XOR), 16'hAAAA, 16'hFFFF, 1'b0, 0, "xor");
    run_op(3'(OP_NOT), 16'h00FF, 16'h1234, 1'b1, 0, "not");
    run_op(3'b111,     16'h5A5A, 16'hA5A5, 1'b1, 0, "reserved");
    run_op(3'(OP_OR),  16'h1200, 16'h0034, 1'b0, 1, "start_in_run");
    run_op(3'(OP_SUB), 16'h0001, 16'h0002, 1'b0, 0, "sub_borrow");

    // Reset at cnt=2 of an ADD discards the partial result and prior cout
    @(negedge clk);
    start = 1'b1; op = 3'(OP_ADD); opa = 16'h1111; opb = 16'h2222; cin = 1'b0;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    check("rst_mid_run", 32'({busy, done, cout, zero, result}), 32'd0);
    pulses = 0;
    repeat (8) begin
      @(posedge clk); @(negedge clk);
      if (done || busy) pulses++;
    end
    check("rst_no_done", 32'(pulses), 32'd0);
    run_op(3'(OP_ADD), 16'h1234, 16'h4321, 1'b1, 0, "after_rst");

    // start held high: two back-to-back ops, done pulses 6 cycles apart
    @(negedge clk);
    start = 1'b1; op = 3'(OP_ADD); opa = 16'h0F0F; opb = 16'h0101; cin = 1'b0;
    ref_op(3'(OP_ADD), 16'h0F0F, 16'h0101, 1'b0, er, ec);
    first_done = -1; second_done = -1; cyc = 0;
    while (second_done < 0 && cyc < 30) begin
      @(posedge clk); @(negedge clk);
      cyc++;
      if (done) begin
        if (first_done < 0) first_done = cyc;
        else second_done = cyc;
      end
    end
    start = 1'b0;
    check("held_start_spacing", 32'(second_done - first_done), 32'd6);
    check("held_start_result", 32'(result), 32'(er));
    @(negedge clk);

    // Randomized ops against the word-level reference
    for (int i = 0; i < 24; i++)
      run_op(3'($urandom_range(0, 7)), W'($urandom), W'($urandom),
             1'($urandom_range(0, 1)), 0, "random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
